// File: rtl/elm_link_pkg.sv
// elm_link_pkg: constants and state encoding shared by both ends of the ELM 16-bit word link
package elm_link_pkg;
    localparam int WORD_W = 16;
    localparam int NUM_WORDS = 16;
    localparam int CNT_W = 5;
    localparam int VEC_W = WORD_W * NUM_WORDS;
    localparam int ACK_TIMEOUT = 64;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, WAIT_ACK = 2'd2} state_e;
endpackage

// File: rtl/elm_serializer_if.sv
// elm_serializer_if: parallel load, serial word stream and handshake of the ELM serializer
interface elm_serializer_if;
    import elm_link_pkg::*;
    logic [VEC_W-1:0] parallel_data;
    logic start;
    logic hold;
    logic ack;
    logic [WORD_W-1:0] serial_data;
    logic [CNT_W-1:0] count;
    logic tx;
    logic busy;
    logic done;
    modport master (output parallel_data, start, hold, ack, input serial_data, count, tx, busy, done);
    modport slave (input parallel_data, start, hold, ack, output serial_data, count, tx, busy, done);
endinterface

// File: rtl/elm_serializer.sv
// elm_serializer: streams a 256-bit vector as sixteen 16-bit words, MSW first, then waits for ack.
// SER_ACK_TIMEOUT_EN adds err_o and abandons WAIT_ACK after ACK_TIMEOUT cycles without ack.
module elm_serializer
    import elm_link_pkg::*;
(
    input  logic clk,
    input  logic rst,
    elm_serializer_if.slave link_if
`ifdef SER_ACK_TIMEOUT_EN
    ,
    output logic err_o
`endif
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);
    state_e state_q, state_d;
    logic [VEC_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, count_q, count_d;
    logic [WORD_W-1:0] ser_q, ser_d;
    logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic load, emit, to_hit;
    assign load = state_q == IDLE && link_if.start;
    assign emit = state_q == SHIFT && !link_if.hold;
`ifdef SER_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT);
    logic [TO_W-1:0] to_q, to_d;
    logic err_q;
    // ack on the final timeout cycle still wins over the timeout
    assign to_hit = state_q == WAIT_ACK && !link_if.ack && to_q == TO_W'(ACK_TIMEOUT - 1);
    assign to_d = state_q == WAIT_ACK ? to_q + TO_W'(1) : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_q <= '0;
            err_q <= 1'b0;
        end else begin
            to_q <= to_d;
            err_q <= to_hit;
        end
    end
    assign err_o = err_q;
`else
    assign to_hit = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = link_if.start ? SHIFT : IDLE;
            SHIFT: state_d = (emit && cnt_q == '0) ? WAIT_ACK : SHIFT;
            WAIT_ACK: state_d = (link_if.ack || to_hit) ? IDLE : WAIT_ACK;
            default: state_d = IDLE;
        endcase
    end
    // count_q is the registered copy seen by the receiver; cnt_q runs one word ahead of it
    always_comb begin
        shift_d = load ? link_if.parallel_data : emit ? {shift_q[VEC_W-WORD_W-1:0], {WORD_W{1'b0}}} : shift_q;
        cnt_d = load ? LAST : emit ? cnt_q - CNT_W'(1) : cnt_q;
        ser_d = emit ? shift_q[VEC_W-1 -: WORD_W] : ser_q;
        count_d = emit ? cnt_q : (state_q == WAIT_ACK && state_d == IDLE) ? LAST : count_q;
        tx_d = emit;
        busy_d = state_d != IDLE;
        done_d = state_q == WAIT_ACK && link_if.ack;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q <= LAST;
            count_q <= LAST;
            ser_q <= '0;
            tx_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q <= cnt_d;
            count_q <= count_d;
            ser_q <= ser_d;
            tx_q <= tx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign link_if.serial_data = ser_q;
    assign link_if.count = count_q;
    assign link_if.tx = tx_q;
    assign link_if.busy = busy_q;
    assign link_if.done = done_q;
endmodule

// File: tb/tb_elm_serializer.sv
// tb_elm_serializer: scoreboard bench with a behavioural receiver shifting words in at the low end
module tb_elm_serializer;
    import elm_link_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    elm_serializer_if link_if();
`ifdef SER_ACK_TIMEOUT_EN
    logic err;
    elm_serializer dut (.clk(clk), .rst(rst), .link_if(link_if), .err_o(err));
`else
    elm_serializer dut (.clk(clk), .rst(rst), .link_if(link_if));
`endif
    always #5 clk = ~clk;
    int cyc = 0, total = 0, bad = 0, ntx = 0, nlast = 0, first_cyc = 0, last_cyc = 0;
    logic [VEC_W-1:0] rx_vec = '0;
    logic [CNT_W-1:0] prev_cnt = '0;
    logic [WORD_W-1:0] prev_ser = '0;
    logic [CNT_W+WORD_W-1:0] sb[$];
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (!rst) begin
            if (link_if.tx) begin
                if (sb.size() == 0) check("unexpected_tx", link_if.tx, 1'b0);
                else check("word", {link_if.count, link_if.serial_data}, sb.pop_front());
                rx_vec = {rx_vec[VEC_W-WORD_W-1:0], link_if.serial_data};
                ntx++;
                if (link_if.count == CNT_W'(NUM_WORDS - 1)) first_cyc = cyc;
                if (link_if.count == '0) begin
                    last_cyc = cyc;
                    nlast++;
                end
            end else if (link_if.busy) begin
                check("hold_cnt", link_if.count, prev_cnt);
                check("hold_dat", link_if.serial_data, prev_ser);
            end
            prev_cnt = link_if.count;
            prev_ser = link_if.serial_data;
        end
    end
    task automatic push_vec(input logic [VEC_W-1:0] v);
        for (int k = 0; k < NUM_WORDS; k++)
            sb.push_back({CNT_W'(NUM_WORDS - 1 - k), v[VEC_W-1-WORD_W*k -: WORD_W]});
    endtask
    task automatic xfer(input logic [VEC_W-1:0] v, input int h1, input int h2, input bit spur, input bit do_ack);
        int c0, nl0;
        push_vec(v);
        nl0 = nlast;
        link_if.parallel_data = v;
        link_if.start = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        link_if.start = 1'b0;
        check("busy_rise", link_if.busy, 1'b1);
        for (int j = 1; j <= 60 && nlast == nl0; j++) begin
            link_if.hold = j == h1 || j == h1 + 1 || j == h2 || j == h2 + 1;
            link_if.start = spur && j == 5;
            link_if.parallel_data = (spur && j == 5) ? ~v : v;
            link_if.ack = spur && j == 7;
            @(posedge clk); #1;
            check("no_done_shift", link_if.done, 1'b0);
        end
        link_if.hold = 1'b0;
        link_if.start = 1'b0;
        link_if.ack = 1'b0;
        check("last_seen", nlast - nl0, 1);
        check("first_lat", first_cyc - c0, 1);
        check("span", last_cyc - first_cyc, 15 + (h1 > 0 ? 2 : 0) + (h2 > 0 ? 2 : 0));
        check("sb_drained", sb.size(), 0);
        check("rx_vec", rx_vec, v);
        check("busy_wait", link_if.busy, 1'b1);
        check("count_wait", link_if.count, 0);
        if (do_ack) begin
            link_if.ack = 1'b1;
            link_if.start = spur;
            link_if.parallel_data = ~v;
            @(posedge clk); #1;
            link_if.ack = 1'b0;
            link_if.start = 1'b0;
            check("done", link_if.done, 1'b1);
            check("busy_fall", link_if.busy, 1'b0);
            check("count_reload", link_if.count, NUM_WORDS - 1);
            @(posedge clk); #1;
            check("done_pulse", link_if.done, 1'b0);
            check("idle_after_ack", link_if.busy, 1'b0);
        end
    endtask
    initial begin
        logic [VEC_W-1:0] v1, vr;
        int n0;
        link_if.parallel_data = '0;
        link_if.start = 1'b0;
        link_if.hold = 1'b0;
        link_if.ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", link_if.tx, 1'b0);
        check("rst_busy", link_if.busy, 1'b0);
        check("rst_done", link_if.done, 1'b0);
        check("rst_count", link_if.count, NUM_WORDS - 1);
        check("rst_ser", link_if.serial_data, 0);
`ifdef SER_ACK_TIMEOUT_EN
        check("rst_err", err, 1'b0);
`endif
        rst = 1'b0;
        for (int k = 0; k < NUM_WORDS; k++) v1[VEC_W-1-WORD_W*k -: WORD_W] = WORD_W'(k + 1);
        xfer(v1, -10, -10, 1'b0, 1'b1);
        xfer(v1, 3, 9, 1'b0, 1'b1);
        for (int k = 0; k < VEC_W / 32; k++) vr[32*k +: 32] = $urandom;
        xfer(vr, -10, -10, 1'b0, 1'b1);
        for (int k = 0; k < VEC_W / 32; k++) vr[32*k +: 32] = $urandom;
        xfer(vr, -10, -10, 1'b1, 1'b1);
        push_vec(v1);
        n0 = ntx;
        link_if.parallel_data = v1;
        link_if.start = 1'b1;
        @(posedge clk); #1;
        link_if.start = 1'b0;
        for (int j = 0; j < 40 && ntx - n0 < 8; j++) begin
            @(negedge clk); #1;
        end
        check("rst_reach_w7", ntx - n0, 8);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", link_if.tx, 1'b0);
        check("mid_rst_busy", link_if.busy, 1'b0);
        check("mid_rst_count", link_if.count, NUM_WORDS - 1);
        check("mid_rst_ser", link_if.serial_data, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < VEC_W / 32; k++) vr[32*k +: 32] = $urandom;
        xfer(vr, -10, -10, 1'b0, 1'b1);
`ifdef SER_ACK_TIMEOUT_EN
        begin
            int ecyc;
            ecyc = -1;
            xfer(v1, -10, -10, 1'b0, 1'b0);
            for (int j = 0; j < 100 && ecyc < 0; j++) begin
                @(posedge clk); #1;
                check("to_no_done", link_if.done, 1'b0);
                if (err) ecyc = cyc;
            end
            check("err_seen", ecyc >= 0, 1'b1);
            check("err_lat", ecyc - last_cyc, ACK_TIMEOUT);
            check("err_idle", link_if.busy, 1'b0);
            @(posedge clk); #1;
            check("err_pulse", err, 1'b0);
            xfer(vr, -10, -10, 1'b0, 1'b1);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
